// File: rtl/zjh_voter.sv
// N-channel bitwise voter: registered input stage, vote stage with a
// persistence filter on the result, per-channel disagreement flags and a
// saturating disagreement counter.
module zjh_voter #(
   parameter int N    = 3,
   parameter int W    = 1,
   parameter int FILT = 2,
   parameter int CW   = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic           in_valid,
   input  logic [N*W-1:0] din,
   input  logic [1:0]     mode,
   input  logic           clr_cnt,
   output logic [W-1:0]   y,
   output logic           out_valid,
   output logic [N-1:0]   ch_err,
   output logic [CW-1:0]  err_cnt
);

   typedef enum logic [1:0] {
      VOTE_MAJ = 2'b00,
      VOTE_MIN = 2'b01,
      VOTE_AND = 2'b10,
      VOTE_OR  = 2'b11
   } vote_mode_t;

   localparam logic [3:0] FILT_V = 4'(FILT);

   logic [N*W-1:0] din_q;
   vote_mode_t     mode_q;
   logic           s1_valid;

   logic [W-1:0]   cand;
   logic [3:0]     stab;

   logic [W-1:0]   maj;
   logic [W-1:0]   vote;
   logic [N-1:0]   ch_err_nx;
   logic [3:0]     stab_nx;

   // Per-bit vote functions over the registered channels; channel errors
   // are always judged against the majority, whatever the mode.
   always_comb begin
      maj       = '0;
      vote      = '0;
      ch_err_nx = '0;
      for (int unsigned b = 0; b < W; b++) begin
         logic [4:0] ones;
         logic       all1;
         logic       any1;
         ones = '0;
         all1 = 1'b1;
         any1 = 1'b0;
         for (int unsigned k = 0; k < N; k++) begin
            ones = ones + 5'(din_q[k*W + b]);
            all1 = all1 & din_q[k*W + b];
            any1 = any1 | din_q[k*W + b];
         end
         maj[b] = (ones > 5'(N / 2));
         case (mode_q)
            VOTE_MAJ: vote[b] = maj[b];
            VOTE_MIN: vote[b] = ~maj[b];
            VOTE_AND: vote[b] = all1;
            default:  vote[b] = any1;
         endcase
      end
      for (int unsigned k = 0; k < N; k++) begin
         ch_err_nx[k] = (din_q[k*W +: W] != maj);
      end
   end

   // Filter stability counter: restart on a new candidate, else count up to FILT.
   always_comb begin
      stab_nx = 4'd1;
      if (vote == cand) begin
         stab_nx = (stab >= FILT_V) ? FILT_V : stab + 4'd1;
      end
   end

   // Input stage: capture sample and mode, track stage-1 valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_q    <= '0;
         mode_q   <= VOTE_MAJ;
         s1_valid <= 1'b0;
      end else if (en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            din_q  <= din;
            mode_q <= vote_mode_t'(mode);
         end
      end
   end

   // Vote stage: filter, output, error flags and counter; en=0 freezes all but out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand      <= '0;
         stab      <= '0;
         y         <= '0;
         out_valid <= 1'b0;
         ch_err    <= '0;
         err_cnt   <= '0;
      end else if (!en) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            cand   <= vote;
            stab   <= stab_nx;
            ch_err <= ch_err_nx;
            if (stab_nx == FILT_V) begin
               y <= vote;
            end
         end
         if (clr_cnt) begin
            err_cnt <= '0;
         end else if (s1_valid && (ch_err_nx != '0) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_zjh_voter.sv
// Directed-vector bench for zjh_voter (N=3, W=4, FILT=2); a second instance
// with CW=2 shares all inputs to exercise counter saturation.
module tb_zjh_voter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic        in_valid = 1'b0;
   logic [11:0] din = '0;
   logic [1:0]  mode = 2'b00;
   logic        clr_cnt = 1'b0;

   logic [3:0]  y, y2;
   logic        out_valid, out_valid2;
   logic [2:0]  ch_err, ch_err2;
   logic [7:0]  err_cnt;
   logic [1:0]  err_cnt2;

   int n_chk  = 0;
   int n_pass = 0;

   zjh_voter #(.N(3), .W(4), .FILT(2), .CW(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .din(din),
      .mode(mode), .clr_cnt(clr_cnt), .y(y), .out_valid(out_valid),
      .ch_err(ch_err), .err_cnt(err_cnt)
   );

   zjh_voter #(.N(3), .W(4), .FILT(2), .CW(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .din(din),
      .mode(mode), .clr_cnt(clr_cnt), .y(y2), .out_valid(out_valid2),
      .ch_err(ch_err2), .err_cnt(err_cnt2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated sample: accepted at first edge, result visible after the second.
   task automatic sample(input logic [11:0] d, input logic [1:0] m);
      din = d;
      mode = m;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #4;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      // reset state
      #2;
      check("rst_y", 32'(y), 0);
      check("rst_ov", 32'(out_valid), 0);
      check("rst_cherr", 32'(ch_err), 0);
      check("rst_cnt", 32'(err_cnt), 0);
      #2 rst_n = 1'b1;
      tick();

      // majority, ch2 disagrees
      sample(12'h5AA, 2'b00);
      check("maj1_ov", 32'(out_valid), 1);
      check("maj1_y", 32'(y), 0);
      check("maj1_cherr", 32'(ch_err), 3'b100);
      check("maj1_cnt", 32'(err_cnt), 1);
      sample(12'h5AA, 2'b00);
      check("maj2_y", 32'(y), 4'hA);
      check("maj2_cherr", 32'(ch_err), 3'b100);
      check("maj2_cnt", 32'(err_cnt), 2);
      tick();
      check("maj_ov_pulse", 32'(out_valid), 0);

      // minority: result inverted, ch_err still vs majority
      do_reset();
      sample(12'h5AA, 2'b01);
      check("min1_y", 32'(y), 0);
      sample(12'h5AA, 2'b01);
      check("min2_y", 32'(y), 4'h5);
      check("min2_cherr", 32'(ch_err), 3'b100);

      // AND / OR over the same channels: A&A&5=0, A|A|5=F
      do_reset();
      sample(12'h5AA, 2'b11);
      sample(12'h5AA, 2'b11);
      check("or_y", 32'(y), 4'hF);
      sample(12'h5AA, 2'b10);
      check("and1_y", 32'(y), 4'hF);
      sample(12'h5AA, 2'b10);
      check("and2_y", 32'(y), 4'h0);

      // alternating majority never settles
      do_reset();
      for (int i = 0; i < 6; i++) begin
         sample((i % 2 == 0) ? 12'hFFF : 12'h000, 2'b00);
         check("alt_y", 32'(y), 0);
      end
      sample(12'hFFF, 2'b00);
      check("alt_f1_y", 32'(y), 0);
      sample(12'hFFF, 2'b00);
      check("alt_f2_y", 32'(y), 4'hF);
      check("alt_cnt", 32'(err_cnt), 0);
      check("alt_cherr", 32'(ch_err), 0);

      // back-to-back samples, one per cycle
      do_reset();
      din = 12'h5AA;
      mode = 2'b00;
      in_valid = 1'b1;
      tick();
      check("b2b_e1_ov", 32'(out_valid), 0);
      tick();
      check("b2b_e2_ov", 32'(out_valid), 1);
      check("b2b_e2_y", 32'(y), 0);
      tick();
      check("b2b_e3_ov", 32'(out_valid), 1);
      check("b2b_e3_y", 32'(y), 4'hA);
      in_valid = 1'b0;
      tick();
      check("b2b_e4_ov", 32'(out_valid), 1);
      check("b2b_e4_cnt", 32'(err_cnt), 3);
      tick();
      check("b2b_e5_ov", 32'(out_valid), 0);

      // saturation on CW=2, then clear beats a simultaneous increment
      do_reset();
      for (int i = 0; i < 5; i++) begin
         sample(12'h5AA, 2'b00);
         check("sat_cnt2", 32'(err_cnt2), (i < 3) ? i + 1 : 3);
      end
      check("sat_cnt8", 32'(err_cnt), 5);
      din = 12'h5AA;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      check("clr_ov", 32'(out_valid), 1);
      check("clr_cnt2", 32'(err_cnt2), 0);
      check("clr_cnt8", 32'(err_cnt), 0);
      check("clr_cherr", 32'(ch_err), 3'b100);

      // en=0 drops in_valid and freezes state
      en = 1'b0;
      din = 12'hFFF;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("en0_ov", 32'(out_valid), 0);
      end
      check("en0_y", 32'(y), 4'hA);
      check("en0_cnt", 32'(err_cnt), 0);
      in_valid = 1'b0;
      en = 1'b1;
      tick();
      check("en0_drop_ov", 32'(out_valid), 0);
      tick();
      check("en0_drop_ov2", 32'(out_valid), 0);

      // pending stage-1 sample survives an en=0 stall
      din = 12'h5AA;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      en = 1'b0;
      tick();
      check("stall_ov1", 32'(out_valid), 0);
      tick();
      check("stall_ov2", 32'(out_valid), 0);
      en = 1'b1;
      tick();
      check("stall_ov3", 32'(out_valid), 1);
      check("stall_cnt", 32'(err_cnt), 1);

      // asynchronous reset mid-stream
      din = 12'h5AA;
      in_valid = 1'b1;
      tick();
      tick();
      check("pre_rst_ov", 32'(out_valid), 1);
      #2 rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      check("arst_ov", 32'(out_valid), 0);
      check("arst_y", 32'(y), 0);
      check("arst_cherr", 32'(ch_err), 0);
      check("arst_cnt", 32'(err_cnt), 0);
      #3 rst_n = 1'b1;
      tick();
      check("post_rst_ov1", 32'(out_valid), 0);
      tick();
      check("post_rst_ov2", 32'(out_valid), 0);
      sample(12'h5AA, 2'b00);
      check("post_rst_y", 32'(y), 0);
      check("post_rst_cnt", 32'(err_cnt), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
